// File: rtl/attn_credit_tx.sv
`default_nettype none
// ============================================================================
// Module      : attn_credit_tx
// Description : Credit-flow-controlled transmitter that buffers 9-bit ex
//               results and sends each as a low byte beat then a high beat.
// Revision    : 1.0 - initial release
// ============================================================================
module attn_credit_tx #(
    parameter int DEPTH        = 4,
    parameter int INIT_CREDITS = 2,
    parameter int MAX_CREDITS  = 4,
    parameter int CW           = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [8:0]    in_data,
    input  logic          in_valid,
    output logic          in_ready,
    output logic [7:0]    tx_data,
    output logic          tx_valid,
    output logic          tx_last,
    input  logic          credit_ret,
    output logic [CW-1:0] credit_cnt,
    output logic          err_ovf
);

    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LO   = 2'd1,
        S_HI   = 2'd2
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;

    logic [8:0]    r_mem [DEPTH];
    logic [AW:0]   r_wr_ptr;
    logic [AW:0]   r_rd_ptr;
    logic [CW-1:0] r_credit;
    logic [CW-1:0] w_credit_nxt;
    logic          r_err_ovf;
    logic          w_ovf_set;
    logic [7:0]    r_tx_data;
    logic          r_tx_valid;
    logic          r_tx_last;
    logic [7:0]    w_tx_data_nxt;
    logic          w_tx_valid_nxt;
    logic          w_tx_last_nxt;

    logic          w_full;
    logic          w_empty;
    logic          w_push;
    logic          w_pop;
    logic          w_start;
    logic [8:0]    w_head;

    // Extra pointer MSB distinguishes full from empty when the indices match.
    assign w_empty  = (r_wr_ptr == r_rd_ptr);
    assign w_full   = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                      (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign in_ready = !w_full;
    assign w_push   = in_valid && !w_full;
    assign w_head   = r_mem[r_rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr[AW-1:0]] <= in_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_tx_data  <= '0;
            r_tx_valid <= 1'b0;
            r_tx_last  <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_tx_data  <= w_tx_data_nxt;
            r_tx_valid <= w_tx_valid_nxt;
            r_tx_last  <= w_tx_last_nxt;
        end
    end

    // The start decision uses the registered count, so a credit returned
    // this cycle only becomes usable next cycle.
    always_comb begin
        w_state_nxt    = r_state;
        w_start        = 1'b0;
        w_pop          = 1'b0;
        w_tx_data_nxt  = r_tx_data;
        w_tx_valid_nxt = 1'b0;
        w_tx_last_nxt  = 1'b0;
        case (r_state)
            S_IDLE, S_HI: begin
                if (!w_empty && (r_credit != '0)) begin
                    w_state_nxt    = S_LO;
                    w_start        = 1'b1;
                    w_tx_data_nxt  = w_head[7:0];
                    w_tx_valid_nxt = 1'b1;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_LO: begin
                w_state_nxt    = S_HI;
                w_pop          = 1'b1;
                w_tx_data_nxt  = {7'b0, w_head[8]};
                w_tx_valid_nxt = 1'b1;
                w_tx_last_nxt  = 1'b1;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_comb begin
        w_credit_nxt = r_credit;
        w_ovf_set    = 1'b0;
        if (credit_ret && !w_start) begin
            if (r_credit == CW'(MAX_CREDITS)) begin
                w_ovf_set = 1'b1;
            end else begin
                w_credit_nxt = r_credit + CW'(1);
            end
        end else if (!credit_ret && w_start) begin
            w_credit_nxt = r_credit - CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_credit  <= CW'(INIT_CREDITS);
            r_err_ovf <= 1'b0;
        end else begin
            r_credit <= w_credit_nxt;
            if (w_ovf_set) r_err_ovf <= 1'b1;
        end
    end

    assign tx_data    = r_tx_data;
    assign tx_valid   = r_tx_valid;
    assign tx_last    = r_tx_last;
    assign credit_cnt = r_credit;
    assign err_ovf    = r_err_ovf;

endmodule
`default_nettype wire

// File: tb/tb_attn_credit_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_attn_credit_tx
// Description : Directed self-checking bench for attn_credit_tx.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_attn_credit_tx;

    logic       clk;
    logic       rst_n;
    logic [8:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_last;
    logic       credit_ret;
    logic [2:0] credit_cnt;
    logic       err_ovf;

    int total = 0;
    int bad   = 0;

    attn_credit_tx #(
        .DEPTH        (4),
        .INIT_CREDITS (2),
        .MAX_CREDITS  (4),
        .CW           (3)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_last    (tx_last),
        .credit_ret (credit_ret),
        .credit_cnt (credit_cnt),
        .err_ovf    (err_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic beat(input string tag, input logic v, input logic l, input logic [7:0] d);
        chk({tag, ".valid"}, 32'(tx_valid), 32'(v));
        chk({tag, ".last"},  32'(tx_last),  32'(l));
        chk({tag, ".data"},  32'(tx_data),  32'(d));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #3;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    logic [8:0] words [4];

    initial begin
        rst_n      = 1'b0;
        in_valid   = 1'b0;
        in_data    = '0;
        credit_ret = 1'b0;
        words[0]   = 9'h1C3;
        words[1]   = 9'h0B4;
        words[2]   = 9'h145;
        words[3]   = 9'h0D6;

        // Reset state
        repeat (2) tick();
        beat("rst", 1'b0, 1'b0, 8'h00);
        chk("rst.credit", 32'(credit_cnt), 32'd2);
        chk("rst.in_ready", 32'(in_ready), 32'd1);
        chk("rst.err", 32'(err_ovf), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Single word latency
        in_data = 9'h1A5; in_valid = 1'b1;
        #1;
        chk("t1.in_ready", 32'(in_ready), 32'd1);
        chk("t1.credit0", 32'(credit_cnt), 32'd2);
        tick(); in_valid = 1'b0;
        chk("t1.nobypass", 32'(tx_valid), 32'd0);
        tick(); beat("t1.b0", 1'b1, 1'b0, 8'hA5);
        chk("t1.credit1", 32'(credit_cnt), 32'd1);
        tick(); beat("t1.b1", 1'b1, 1'b1, 8'h01);
        tick(); beat("t1.idle", 1'b0, 1'b0, 8'h01);
        chk("t1.credit_end", 32'(credit_cnt), 32'd1);

        // Three words, two credits
        do_reset();
        in_valid = 1'b1; in_data = 9'h011;
        tick(); chk("t2.e1", 32'(tx_valid), 32'd0);
        in_data = 9'h122;
        tick(); beat("t2.w0lo", 1'b1, 1'b0, 8'h11);
        chk("t2.credit_a", 32'(credit_cnt), 32'd1);
        in_data = 9'h033;
        tick(); beat("t2.w0hi", 1'b1, 1'b1, 8'h00);
        in_valid = 1'b0;
        tick(); beat("t2.w1lo", 1'b1, 1'b0, 8'h22);
        chk("t2.credit_b", 32'(credit_cnt), 32'd0);
        tick(); beat("t2.w1hi", 1'b1, 1'b1, 8'h01);
        tick(); beat("t2.stall", 1'b0, 1'b0, 8'h01);
        chk("t2.credit_c", 32'(credit_cnt), 32'd0);
        credit_ret = 1'b1;
        tick(); credit_ret = 1'b0;
        chk("t2.ret_valid", 32'(tx_valid), 32'd0);
        chk("t2.ret_credit", 32'(credit_cnt), 32'd1);
        tick(); beat("t2.w2lo", 1'b1, 1'b0, 8'h33);
        chk("t2.credit_d", 32'(credit_cnt), 32'd0);
        tick(); beat("t2.w2hi", 1'b1, 1'b1, 8'h00);
        tick(); chk("t2.idle", 32'(tx_valid), 32'd0);

        // Fill the FIFO with no credits
        for (int i = 0; i < 4; i++) begin
            in_data = words[i]; in_valid = 1'b1;
            tick();
            if (i == 2) chk("t3.ready_after3", 32'(in_ready), 32'd1);
        end
        chk("t3.full", 32'(in_ready), 32'd0);
        in_data = 9'h1E7;
        tick(); chk("t3.held", 32'(in_ready), 32'd0);
        chk("t3.novalid", 32'(tx_valid), 32'd0);
        credit_ret = 1'b1;
        tick(); credit_ret = 1'b0;
        chk("t3.credit1", 32'(credit_cnt), 32'd1);
        tick(); beat("t3.alo", 1'b1, 1'b0, 8'hC3);
        chk("t3.still_full", 32'(in_ready), 32'd0);
        tick(); beat("t3.ahi", 1'b1, 1'b1, 8'h01);
        chk("t3.ready_after_pop", 32'(in_ready), 32'd1);
        tick(); in_valid = 1'b0;
        chk("t3.full_again", 32'(in_ready), 32'd0);
        chk("t3.idle", 32'(tx_valid), 32'd0);

        // Credit return coinciding with a send start
        credit_ret = 1'b1;
        tick(); chk("t4.credit1", 32'(credit_cnt), 32'd1);
        tick(); credit_ret = 1'b0;
        beat("t4.blo", 1'b1, 1'b0, 8'hB4);
        chk("t4.credit_same", 32'(credit_cnt), 32'd1);
        tick(); beat("t4.bhi", 1'b1, 1'b1, 8'h00);
        tick(); beat("t4.clo", 1'b1, 1'b0, 8'h45);
        chk("t4.credit0", 32'(credit_cnt), 32'd0);
        tick(); beat("t4.chi", 1'b1, 1'b1, 8'h01);
        tick(); chk("t4.idle", 32'(tx_valid), 32'd0);
        credit_ret = 1'b1;
        tick(); credit_ret = 1'b0;
        tick(); beat("t4.dlo", 1'b1, 1'b0, 8'hD6);
        tick(); beat("t4.dhi", 1'b1, 1'b1, 8'h00);
        tick(); chk("t4.idle2", 32'(tx_valid), 32'd0);
        credit_ret = 1'b1;
        tick(); credit_ret = 1'b0;
        tick(); beat("t4.elo", 1'b1, 1'b0, 8'hE7);
        tick(); beat("t4.ehi", 1'b1, 1'b1, 8'h01);
        tick(); chk("t4.idle3", 32'(tx_valid), 32'd0);
        chk("t4.credit_end", 32'(credit_cnt), 32'd0);
        chk("t4.empty", 32'(in_ready), 32'd1);

        // Credit overflow
        credit_ret = 1'b1;
        repeat (4) tick();
        credit_ret = 1'b0;
        chk("t5.credit_max", 32'(credit_cnt), 32'd4);
        chk("t5.err_clear", 32'(err_ovf), 32'd0);
        credit_ret = 1'b1;
        tick(); credit_ret = 1'b0;
        chk("t5.credit_held", 32'(credit_cnt), 32'd4);
        chk("t5.err_set", 32'(err_ovf), 32'd1);
        tick(); chk("t5.err_sticky", 32'(err_ovf), 32'd1);

        // Asynchronous reset during a LO beat
        in_data = 9'h0AA; in_valid = 1'b1;
        tick(); in_valid = 1'b0;
        tick(); beat("t6.lo", 1'b1, 1'b0, 8'hAA);
        chk("t6.credit3", 32'(credit_cnt), 32'd3);
        #2 rst_n = 1'b0;
        #1;
        beat("t6.async", 1'b0, 1'b0, 8'h00);
        chk("t6.credit", 32'(credit_cnt), 32'd2);
        chk("t6.in_ready", 32'(in_ready), 32'd1);
        chk("t6.err", 32'(err_ovf), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t6.quiet", 32'(tx_valid), 32'd0);
        end
        in_data = 9'h155; in_valid = 1'b1;
        tick(); in_valid = 1'b0;
        tick(); beat("t6.nlo", 1'b1, 1'b0, 8'h55);
        tick(); beat("t6.nhi", 1'b1, 1'b1, 8'h01);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
